// File: rtl/ram_arbiter.sv
// Shared program/data RAM with a round-robin two-port arbiter.
// The host lock gives the loader exclusive access; contended cycles are counted.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              hst_req,
  input  logic              hst_we,
  input  logic [ADDR_W-1:0] hst_addr,
  input  logic [DATA_W-1:0] hst_wdata,
  output logic              hst_gnt,
  output logic              hst_rvalid,
  output logic [DATA_W-1:0] hst_rdata,
  input  logic              hst_lock,
  output logic              cpu_stall,
  output logic [7:0]        conflict_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [7:0]  CNT_MAX = 8'hFF;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_last;        // 0 = CPU won last, 1 = host won last
  logic              r_cpu_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_hst_rvalid;
  logic [DATA_W-1:0] r_hst_rdata;
  logic [7:0]        r_conflict_cnt;

  logic              w_cpu_gnt;
  logic              w_hst_gnt;
  logic              w_both_req;

  assign w_both_req = cpu_req & hst_req;

  // Grant: lock overrides everything, otherwise the loser of the last grant wins ties.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_hst_gnt = 1'b0;
    if (hst_lock) begin
      w_hst_gnt = hst_req;
    end else if (w_both_req) begin
      w_cpu_gnt = r_last;
      w_hst_gnt = ~r_last;
    end else begin
      w_cpu_gnt = cpu_req;
      w_hst_gnt = hst_req;
    end
  end

  assign cpu_gnt      = w_cpu_gnt;
  assign hst_gnt      = w_hst_gnt;
  assign cpu_stall    = cpu_req & ~w_cpu_gnt;
  assign cpu_rvalid   = r_cpu_rvalid;
  assign cpu_rdata    = r_cpu_rdata;
  assign hst_rvalid   = r_hst_rvalid;
  assign hst_rdata    = r_hst_rdata;
  assign conflict_cnt = r_conflict_cnt;

  // Storage: at most one write commits per edge since grants are exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_cpu_gnt && cpu_we) begin
      r_mem[cpu_addr] <= cpu_wdata;
    end else if (w_hst_gnt && hst_we) begin
      r_mem[hst_addr] <= hst_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_hst_rvalid <= 1'b0;
      r_hst_rdata  <= '0;
    end else begin
      r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
      r_hst_rvalid <= w_hst_gnt & ~hst_we;
      if (w_cpu_gnt && !cpu_we) begin
        r_cpu_rdata <= r_mem[cpu_addr];
      end
      if (w_hst_gnt && !hst_we) begin
        r_hst_rdata <= r_mem[hst_addr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last         <= 1'b1;
      r_conflict_cnt <= '0;
    end else begin
      if (w_cpu_gnt) begin
        r_last <= 1'b0;
      end else if (w_hst_gnt) begin
        r_last <= 1'b1;
      end
      if (w_both_req && r_conflict_cnt != CNT_MAX) begin
        r_conflict_cnt <= r_conflict_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter against a behavioural model
// of the shared RAM, grant ownership and conflict counter.
module tb_ram_arbiter;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req, cpu_we, hst_req, hst_we, hst_lock;
  logic [ADDR_W-1:0] cpu_addr, hst_addr;
  logic [DATA_W-1:0] cpu_wdata, hst_wdata;
  logic              cpu_gnt, cpu_rvalid, hst_gnt, hst_rvalid, cpu_stall;
  logic [DATA_W-1:0] cpu_rdata, hst_rdata;
  logic [7:0]        conflict_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_mem [DEPTH];
  int m_owner;          // who was granted most recently: 0 CPU, 1 host
  int m_conflicts;
  int m_crv, m_crd, m_hrv, m_hrd;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .hst_req(hst_req), .hst_we(hst_we), .hst_addr(hst_addr), .hst_wdata(hst_wdata),
    .hst_gnt(hst_gnt), .hst_rvalid(hst_rvalid), .hst_rdata(hst_rdata),
    .hst_lock(hst_lock), .cpu_stall(cpu_stall), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 0;
    m_owner = 1;
    m_conflicts = 0;
    m_crv = 0; m_crd = 0; m_hrv = 0; m_hrd = 0;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    hst_req = 1'b0; hst_we = 1'b0; hst_addr = '0; hst_wdata = '0;
    hst_lock = 1'b0;
  endtask

  task automatic check_regs(input string pfx);
    chk({pfx, "cpu_rvalid"}, 32'(cpu_rvalid), 32'(m_crv));
    chk({pfx, "cpu_rdata"}, 32'(cpu_rdata), 32'(m_crd));
    chk({pfx, "hst_rvalid"}, 32'(hst_rvalid), 32'(m_hrv));
    chk({pfx, "hst_rdata"}, 32'(hst_rdata), 32'(m_hrd));
    chk({pfx, "conflict_cnt"}, 32'(conflict_cnt), 32'(m_conflicts));
  endtask

  // One clock: called at negedge with inputs already driven; returns model grants.
  task automatic step(output bit gc, output bit gh);
    int winner;
    #1;
    winner = -1;
    if (hst_lock) begin
      if (hst_req) winner = 1;
    end else if (cpu_req && hst_req) begin
      winner = 1 - m_owner;
    end else if (cpu_req) begin
      winner = 0;
    end else if (hst_req) begin
      winner = 1;
    end
    gc = (winner == 0);
    gh = (winner == 1);
    chk("cpu_gnt", 32'(cpu_gnt), 32'(gc));
    chk("hst_gnt", 32'(hst_gnt), 32'(gh));
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !gc));
    check_regs("");
    @(posedge clk);
    m_crv = 0;
    m_hrv = 0;
    if (gc) begin
      if (cpu_we) m_mem[int'(cpu_addr)] = int'(cpu_wdata);
      else begin m_crv = 1; m_crd = m_mem[int'(cpu_addr)]; end
    end
    if (gh) begin
      if (hst_we) m_mem[int'(hst_addr)] = int'(hst_wdata);
      else begin m_hrv = 1; m_hrd = m_mem[int'(hst_addr)]; end
    end
    if (winner >= 0) m_owner = winner;
    if (cpu_req && hst_req && m_conflicts < 255) m_conflicts++;
    @(negedge clk);
  endtask

  bit gc, gh;
  bit c_pend, h_pend;

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_regs("reset_");
    rst_n = 1'b1;

    // Host loads the whole RAM, then the CPU reads the top word
    for (int i = 0; i < int'(DEPTH); i++) begin
      hst_req = 1'b1; hst_we = 1'b1;
      hst_addr = 4'(i); hst_wdata = {4'(i), 4'(15 - i)};
      step(gc, gh);
    end
    idle_inputs();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd15;
    step(gc, gh);
    idle_inputs();
    chk("load_read_data", 32'(cpu_rdata), 32'h0000_00F0);
    step(gc, gh);

    // Continuous contention: both ports read every cycle
    for (int i = 0; i < 8; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'(i);
      hst_req = 1'b1; hst_we = 1'b0; hst_addr = 4'(15 - i);
      step(gc, gh);
    end

    // Lock: CPU held off for 10 contended cycles, then released
    hst_lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      hst_addr = 4'(i);
      step(gc, gh);
    end
    hst_lock = 1'b0;
    for (int i = 0; i < 3; i++) step(gc, gh);
    idle_inputs();

    // Read-after-write across ports
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd3; cpu_wdata = 8'h55;
    step(gc, gh);
    idle_inputs();
    hst_req = 1'b1; hst_we = 1'b0; hst_addr = 4'd3;
    step(gc, gh);
    idle_inputs();
    chk("raw_hst_rdata", 32'(hst_rdata), 32'h0000_0055);

    // Saturation of the conflict counter
    for (int i = 0; i < 300; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'($urandom_range(0, 15));
      hst_req = 1'b1; hst_we = 1'b0; hst_addr = 4'($urandom_range(0, 15));
      hst_lock = 1'($urandom_range(0, 1));
      step(gc, gh);
    end
    idle_inputs();
    #1;
    chk("cnt_saturated", 32'(conflict_cnt), 32'd255);

    // Async reset during a granted write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd7; cpu_wdata = 8'hAA;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("midrst_");
    idle_inputs();
    #1 rst_n = 1'b1;
    @(negedge clk);
    hst_req = 1'b1; hst_we = 1'b0; hst_addr = 4'd7;
    step(gc, gh);
    idle_inputs();
    chk("midrst_mem7", 32'(hst_rdata), 32'd0);
    step(gc, gh);

    // Randomized traffic: requesters hold until granted, occasionally abandon
    c_pend = 1'b0;
    h_pend = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!c_pend && $urandom_range(0, 2) != 0) begin
        c_pend = 1'b1;
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 4'($urandom_range(0, 15));
        cpu_wdata = 8'($urandom_range(0, 255));
      end else if (c_pend && $urandom_range(0, 15) == 0) begin
        c_pend = 1'b0;
      end
      if (!h_pend && $urandom_range(0, 2) != 0) begin
        h_pend = 1'b1;
        hst_we = 1'($urandom_range(0, 1));
        hst_addr = 4'($urandom_range(0, 15));
        hst_wdata = 8'($urandom_range(0, 255));
      end else if (h_pend && $urandom_range(0, 15) == 0) begin
        h_pend = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) hst_lock = ~hst_lock;
      cpu_req = c_pend;
      hst_req = h_pend;
      step(gc, gh);
      if (gc) c_pend = 1'b0;
      if (gh) h_pend = 1'b0;
    end
    idle_inputs();
    step(gc, gh);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
